// File: rtl/fifo_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl_pkg
//  Description : Shared defaults, counter type and round-robin selector
//                encoding for the FIFO access controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_ctrl_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = $clog2(DEPTH_DEF + 1);

    // Occupancy counter type at the default depth (0..16 needs 5 bits)
    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // Which requester currently holds write priority
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } rr_sel_e;

endpackage : fifo_ctrl_pkg
`default_nettype wire

// File: rtl/fifo_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_access_ctrl_if
//  Description : Bundles the two write requesters, the read consumer, the
//                external FIFO pins and the occupancy status of the
//                controller. The controller uses the slave view, the
//                requesters / FIFO side use the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_access_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    // Write requester 0
    logic             wr_req0;
    logic [WIDTH-1:0] wr_data0;
    logic             wr_gnt0;
    // Write requester 1
    logic             wr_req1;
    logic [WIDTH-1:0] wr_data1;
    logic             wr_gnt1;
    // Read consumer
    logic             rd_req;
    logic             rd_gnt;
    // External FIFO pins
    logic             fifo_wr_n;
    logic             fifo_rd_n;
    logic [WIDTH-1:0] fifo_din;
    logic             fifo_over_flow;
    logic             fifo_under_flow;
    // Status
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             err;

    modport slave (
        input  wr_req0, wr_data0, wr_req1, wr_data1, rd_req,
        input  fifo_over_flow, fifo_under_flow,
        output wr_gnt0, wr_gnt1, rd_gnt,
        output fifo_wr_n, fifo_rd_n, fifo_din,
        output count, full, empty, err
    );

    modport master (
        output wr_req0, wr_data0, wr_req1, wr_data1, rd_req,
        output fifo_over_flow, fifo_under_flow,
        input  wr_gnt0, wr_gnt1, rd_gnt,
        input  fifo_wr_n, fifo_rd_n, fifo_din,
        input  count, full, empty, err
    );

endinterface : fifo_access_ctrl_if
`default_nettype wire

// File: rtl/fifo_access_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. Grant is combinational and
//                one-hot-or-zero; the favoured requester flips to the other
//                side after every grant and holds otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import fifo_ctrl_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] req,
    input  wire logic       en,
    output logic      [1:0] gnt
);

    rr_sel_e r_rr_ptr;
    rr_sel_e w_rr_ptr_nxt;

    // Priority pointer register; requester 0 is favoured out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= REQ0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Grant decode and pointer update: a lone requester always wins,
    // a tie goes to the favoured side
    always_comb begin
        gnt          = 2'b00;
        w_rr_ptr_nxt = r_rr_ptr;
        if (en) begin
            gnt[0] = req[0] & (~req[1] | (r_rr_ptr == REQ0));
            gnt[1] = req[1] & (~req[0] | (r_rr_ptr == REQ1));
        end
        if (gnt[0]) begin
            w_rr_ptr_nxt = REQ1;
        end else if (gnt[1]) begin
            w_rr_ptr_nxt = REQ0;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/fifo_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_access_ctrl
//  Description : Front-end for a 16-deep active-low-strobed FIFO. Arbitrates
//                two write requesters round-robin, grants reads only when
//                data is committed, drives registered FIFO strobes/data one
//                cycle after each grant and latches FIFO error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_access_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
)(
    input  wire logic         clk,
    input  wire logic         rst,
    fifo_access_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [CNT_W-1:0] r_count;
    logic             r_wr_n;
    logic             r_rd_n;
    logic [WIDTH-1:0] r_din;
    logic             r_err;

    logic             w_wr_ok;
    logic [1:0]       w_gnt;
    logic             w_wr_any;
    logic             w_rd_gnt;
    logic [WIDTH-1:0] w_wr_data;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Grants are suppressed during reset; writes only while not full, so a
    // same-cycle read never makes room for a write (no write-through)
    assign w_wr_ok  = (r_count < c_depth) & ~rst;
    assign w_rd_gnt = bus.rd_req & (r_count != '0) & ~rst;

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req ({bus.wr_req1, bus.wr_req0}),
        .en  (w_wr_ok),
        .gnt (w_gnt)
    );

    assign w_wr_any  = |w_gnt;
    assign w_wr_data = w_gnt[1] ? bus.wr_data1 : bus.wr_data0;
    assign w_cnt_nxt = r_count + CNT_W'(w_wr_any) - CNT_W'(w_rd_gnt);

    // Occupancy, strobe/data pipeline and sticky error; reset also drops
    // any strobe that a grant in the reset cycle would have produced
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_din   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_wr_n  <= ~w_wr_any;
            r_rd_n  <= ~w_rd_gnt;
            if (w_wr_any) begin
                r_din <= w_wr_data;
            end
            if (bus.fifo_over_flow || bus.fifo_under_flow) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.wr_gnt0   = w_gnt[0];
    assign bus.wr_gnt1   = w_gnt[1];
    assign bus.rd_gnt    = w_rd_gnt;
    assign bus.fifo_wr_n = r_wr_n;
    assign bus.fifo_rd_n = r_rd_n;
    assign bus.fifo_din  = r_din;
    assign bus.count     = r_count;
    assign bus.full      = (r_count == c_depth);
    assign bus.empty     = (r_count == '0);
    assign bus.err       = r_err;

endmodule : fifo_access_ctrl
`default_nettype wire
